pulse_mode_ctrl: RTL and testbench

PULSE_MODE_CTRL -- requirements
Module: pulse_mode_ctrl

---
 rtl/pulse_mode_ctrl.sv | 131 +++++++++++++
 tb/tb_pulse_mode_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_mode_ctrl.sv
// Pulsed-enable sequencer for a shift-register latch chain: issues N enable pulses of PW cycles separated by 1-cycle gaps.
// Optional build macro MODE_CHECK_EN rejects start requests carrying an invalid mode (101..111) and pulses err.
module pulse_mode_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       abort,
  output logic [2:0] sel,
  output logic       En1,
  output logic       En2,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_PISO = 3'b010;
  localparam logic [2:0] MODE_PIPO = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] pcnt, pcnt_nx, pcnt_inc_c, npulse_c;
  logic [3:0]    pwcnt, pwcnt_nx;
  logic [2:0]    sel_nx;
  logic          en1_nx, en2_nx, busy_nx, done_nx, err_nx;
  logic          bad_mode_c;

`ifdef MODE_CHECK_EN
  assign bad_mode_c = (mode > 3'b100);
`else
  assign bad_mode_c = 1'b0;
`endif

  // Pulse count for the latched operation: a parallel load needs one strobe only.
  assign npulse_c   = (sel == MODE_PIPO) ? CW'(1) : CW'(WIDTH);
  assign pcnt_inc_c = pcnt + CW'(1);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pcnt  <= '0;
      pwcnt <= '0;
      sel   <= '0;
      En1   <= 1'b0;
      En2   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
      pwcnt <= pwcnt_nx;
      sel   <= sel_nx;
      En1   <= en1_nx;
      En2   <= en2_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

`ifdef MODE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= err_nx;
  end
`else
  assign err = 1'b0;
`endif

  // Next state; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    pwcnt_nx = pwcnt;
    sel_nx   = sel;
    err_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (bad_mode_c) begin
            err_nx = 1'b1;
          end else begin
            sel_nx   = mode;
            pcnt_nx  = '0;
            pwcnt_nx = '0;
            state_nx = PULSE;
          end
        end
      end
      PULSE: begin
        if (abort) begin
          pwcnt_nx = '0;
          state_nx = IDLE;
        end else if (pwcnt == 4'(PW - 1)) begin
          pwcnt_nx = '0;
          pcnt_nx  = pcnt_inc_c;
          state_nx = (pcnt_inc_c == npulse_c) ? DONE : GAP;
        end else begin
          pwcnt_nx = pwcnt + 4'd1;
        end
      end
      GAP: begin
        state_nx = abort ? IDLE : PULSE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    en1_nx  = (state_nx == PULSE) && (sel_nx != MODE_PISO);
    en2_nx  = (state_nx == PULSE) && (sel_nx == MODE_PISO);
    busy_nx = (state_nx == PULSE) || (state_nx == GAP);
    done_nx = (state_nx == DONE);
  end

endmodule

// File: tb/tb_pulse_mode_ctrl.sv
// Bench for pulse_mode_ctrl: two instances (PW=1 and PW=2) share stimulus and are checked
// every cycle against an offset-arithmetic reference of the expected enable/busy/done timeline.
module tb_pulse_mode_ctrl;

  localparam int unsigned WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic       abort;

  logic [2:0] sel_o  [2];
  logic       en1_o  [2];
  logic       en2_o  [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       err_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: per instance, offset t since the accepting edge (0 = idle)
  int         pwv  [2] = '{1, 2};
  int         mt   [2];
  int         mn   [2];
  logic [2:0] msel [2];
  logic       merr [2];

  always #5 clk = ~clk;

  pulse_mode_ctrl #(.WIDTH(WIDTH), .PW(1)) u_pw1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .sel(sel_o[0]), .En1(en1_o[0]), .En2(en2_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  pulse_mode_ctrl #(.WIDTH(WIDTH), .PW(2)) u_pw2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .sel(sel_o[1]), .En1(en1_o[1]), .En2(en2_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  function automatic logic is_bad(input logic [2:0] m);
`ifdef MODE_CHECK_EN
    return m > 3'b100;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input int inst, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[pw%0d] @%0t: observed %0h expected %0h", tag, pwv[inst], $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mt[i] = 0; mn[i] = 1; msel[i] = 3'b000; merr[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic s, input logic [2:0] m, input logic a);
    for (int i = 0; i < 2; i++) begin
      int total;
      total   = mn[i] * pwv[i] + mn[i];
      merr[i] = 1'b0;
      if (mt[i] == 0) begin
        if (s && !a) begin
          if (is_bad(m)) merr[i] = 1'b1;
          else begin
            mt[i] = 1; msel[i] = m; mn[i] = (m == 3'b011) ? 1 : WIDTH;
          end
        end
      end else if (mt[i] == total || a) begin
        mt[i] = 0;
      end else begin
        mt[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int   total;
      logic eb, en, ed;
      total = mn[i] * pwv[i] + mn[i];
      eb = (mt[i] >= 1) && (mt[i] < total);
      ed = (mt[i] != 0) && (mt[i] == total);
      en = eb && (((mt[i] - 1) % (pwv[i] + 1)) < pwv[i]);
      check("sel",  i, sel_o[i], msel[i]);
      check("en1",  i, 3'(en1_o[i]),  3'(en && msel[i] != 3'b010));
      check("en2",  i, 3'(en2_o[i]),  3'(en && msel[i] == 3'b010));
      check("busy", i, 3'(busy_o[i]), 3'(eb));
      check("done", i, 3'(done_o[i]), 3'(ed));
      check("err",  i, 3'(err_o[i]),  3'(merr[i]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_sel"}, i, sel_o[i], 3'b000);
      check({tag, "_out"}, i, {en1_o[i] | en2_o[i], busy_o[i] | done_o[i], err_o[i]}, 3'b000);
    end
  endtask

  // One clock: drive inputs, advance reference at the edge, check 1 time unit later
  task automatic cyc(input logic s, input logic [2:0] m, input logic a);
    start = s; mode = m; abort = a;
    @(posedge clk);
    model_step(s, m, a);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'b000; abort = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // SISO: four single/double-cycle pulses on En1
    cyc(1'b1, 3'b000, 1'b0);
    idle(14);

    // PISO: pulses on En2
    cyc(1'b1, 3'b010, 1'b0);
    idle(14);

    // PIPO with start held through the run: only one operation until it returns to IDLE
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    idle(6);

    // SIPO aborted during the second pulse, then restarted
    cyc(1'b1, 3'b001, 1'b0);
    idle(2);
    cyc(1'b0, 3'b000, 1'b1);
    idle(3);
    cyc(1'b1, 3'b001, 1'b0);
    idle(14);

    // abort beats start in IDLE
    cyc(1'b1, 3'b000, 1'b1);
    idle(2);

    // invalid mode
    cyc(1'b1, 3'b110, 1'b0);
    idle(14);

    // rotate
    cyc(1'b1, 3'b100, 1'b0);
    idle(14);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 4) == 0, 3'($urandom % 8), ($urandom % 16) == 0);
    end
    idle(14);

    // asynchronous reset in the middle of an En1 pulse
    cyc(1'b1, 3'b000, 1'b0);
    check("pre_rst_en1", 0, 3'(en1_o[0]), 3'b001);
    #1 rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    check_zero("rst_held");
    rst = 1'b0;
    idle(2);
    cyc(1'b1, 3'b000, 1'b0);
    idle(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
